// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the multi-cycle ALU sequencer: opcodes, control-bit
// indices and the FSM state encoding.
package alu_ctrl_pkg;

    localparam int unsigned CTRL_W = 12;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int unsigned CB_LD_Q    = 0;
    localparam int unsigned CB_LD_M    = 1;
    localparam int unsigned CB_CLR_A   = 2;   // clears A and Q[-1]
    localparam int unsigned CB_XFER_QA = 3;
    localparam int unsigned CB_ADD     = 4;
    localparam int unsigned CB_SUB     = 5;
    localparam int unsigned CB_ASHR    = 6;   // arithmetic shift of A:Q:Q[-1]
    localparam int unsigned CB_LSHL    = 7;   // logical shift left of A:Q
    localparam int unsigned CB_SET_Q0  = 8;   // Q[0] <= ~a_sign
    localparam int unsigned CB_CNT_INC = 9;
    localparam int unsigned CB_OUT_A   = 10;
    localparam int unsigned CB_OUT_Q   = 11;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LDQ    = 4'd1,
        ST_LDM    = 4'd2,
        ST_DISP   = 4'd3,
        ST_ADDSUB = 4'd4,
        ST_MTEST  = 4'd5,
        ST_MSHR   = 4'd6,
        ST_DSHL   = 4'd7,
        ST_DOP    = 4'd8,
        ST_DSETQ  = 4'd9,
        ST_DCORR  = 4'd10,
        ST_OUTA   = 4'd11,
        ST_OUTQ   = 4'd12,
        ST_DONE   = 4'd13,
        ST_ERR    = 4'd14
    } state_e;

endpackage

// File: rtl/alu_step_counter.sv
// Iteration counter for the shift/add loops; flags the final iteration.
module alu_step_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 3
) (
    input  logic clk,
    input  logic rst_b,
    input  logic clr_i,
    input  logic inc_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;

    // Counter register: clear has priority over increment.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign last_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Control sequencer for the A/Q/M ALU datapath: ADD, SUB, Booth MUL and
// non-restoring DIV, emitting one control bit per datapath action.
module alu_seq_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic              q0,
    input  logic              q_m1,
    input  logic              a_sign,
    input  logic              m_zero,
    output logic [CTRL_W-1:0] c,
    output logic              busy,
    output logic              finish,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_e     state_q, state_d;
    logic [1:0] op_q;
    logic       cnt_clr, cnt_inc, cnt_last;

    alu_step_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr_i  (cnt_clr),
        .inc_i  (cnt_inc),
        .last_o (cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Opcode is captured only on acceptance so later op changes are ignored.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            op_q <= OP_ADD;
        end else if (state_q == ST_IDLE && start) begin
            op_q <= op;
        end
    end

    // Next-state and control decode; Mealy terms only in DISP/MTEST/DOP/DCORR.
    always_comb begin
        state_d = state_q;
        c       = '0;
        busy    = 1'b1;
        finish  = 1'b0;
        err     = 1'b0;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_d = ST_LDQ;
            end
            ST_LDQ: begin
                c[CB_LD_Q] = 1'b1;
                state_d    = ST_LDM;
            end
            ST_LDM: begin
                c[CB_LD_M]  = 1'b1;
                c[CB_CLR_A] = 1'b1;
                cnt_clr     = 1'b1;
                state_d     = ST_DISP;
            end
            ST_DISP: begin
                case (op_q)
                    OP_ADD, OP_SUB: begin
                        c[CB_XFER_QA] = 1'b1;
                        state_d       = ST_ADDSUB;
                    end
                    OP_MUL:  state_d = ST_MTEST;
                    default: state_d = m_zero ? ST_ERR : ST_DSHL;
                endcase
            end
            ST_ADDSUB: begin
                if (op_q == OP_SUB) c[CB_SUB] = 1'b1;
                else                c[CB_ADD] = 1'b1;
                state_d = ST_OUTA;
            end
            ST_MTEST: begin
                case ({q0, q_m1})
                    2'b01:   c[CB_ADD] = 1'b1;
                    2'b10:   c[CB_SUB] = 1'b1;
                    default: ;
                endcase
                state_d = ST_MSHR;
            end
            ST_MSHR: begin
                c[CB_ASHR]    = 1'b1;
                c[CB_CNT_INC] = 1'b1;
                if (cnt_last) begin
                    state_d = ST_OUTA;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ST_MTEST;
                end
            end
            ST_DSHL: begin
                c[CB_LSHL] = 1'b1;
                state_d    = ST_DOP;
            end
            ST_DOP: begin
                if (a_sign) c[CB_ADD] = 1'b1;
                else        c[CB_SUB] = 1'b1;
                state_d = ST_DSETQ;
            end
            ST_DSETQ: begin
                c[CB_SET_Q0]  = 1'b1;
                c[CB_CNT_INC] = 1'b1;
                if (cnt_last) begin
                    state_d = ST_DCORR;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = ST_DSHL;
                end
            end
            ST_DCORR: begin
                if (a_sign) c[CB_ADD] = 1'b1;
                state_d = ST_OUTA;
            end
            ST_OUTA: begin
                c[CB_OUT_A] = 1'b1;
                state_d     = op_q[1] ? ST_OUTQ : ST_DONE;
            end
            ST_OUTQ: begin
                c[CB_OUT_Q] = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                finish  = 1'b1;
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
